// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcodes and branch condition codes.
// The opcode encoding matches the ALU's cs select.
package cpu_pkg;

    localparam int DW = 16;
    localparam int RW = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_ADDZ = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_NOR  = 4'b0100,
        OP_SLL  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_LW   = 4'b1000,
        OP_SW   = 4'b1001,
        OP_LHB  = 4'b1010,
        OP_LLB  = 4'b1011,
        OP_B    = 4'b1100,
        OP_JAL  = 4'b1101,
        OP_JR   = 4'b1110,
        OP_HLT  = 4'b1111
    } op_e;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator over the architectural Z/N/V flags.
// Purely combinational.
module br_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       n,
    input  logic       v,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        unique case (cond)
            CC_NE:   take = ~z;
            CC_EQ:   take = z;
            CC_GT:   take = ~z & ~n;
            CC_LT:   take = n;
            CC_GE:   take = z | (~z & ~n);
            CC_LE:   take = n | z;
            CC_OV:   take = v;
            CC_UNC:  take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flag register, branch resolution,
// one-cycle registered redirect and sticky halt latch.
module ex_mem_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [3:0]    ex_op,
    input  logic [DW-1:0] ex_alu_dst,
    input  logic          ex_ov,
    input  logic          ex_z,
    input  logic          ex_n,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_we,
    input  logic [DW-1:0] ex_st_data,
    input  logic [2:0]    ex_cond,
    input  logic [DW-1:0] ex_pc1,
    input  logic [DW-1:0] ex_br_target,
    input  logic [DW-1:0] ex_jr_target,
    input  logic          mem_stall,
    output logic          mem_valid,
    output logic [DW-1:0] mem_result,
    output logic [DW-1:0] mem_st_data,
    output logic [RW-1:0] mem_rd,
    output logic          mem_we,
    output logic          mem_re,
    output logic          mem_wr,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_v,
    output logic          redirect,
    output logic [DW-1:0] redirect_pc,
    output logic          halted
);

    import cpu_pkg::*;

    op_e           op;
    logic          acc;
    logic          take;
    logic          wr_all;
    logic          wr_z;
    logic          we_eff;
    logic          xfer;
    logic [DW-1:0] xfer_pc;
    logic [DW-1:0] res_eff;
    logic [RW-1:0] rd_eff;

    assign op  = op_e'(ex_op);
    assign acc = ex_valid & ~mem_stall & ~redirect & ~halted;

    br_cond_eval u_br_cond_eval (
        .cond (ex_cond),
        .z    (flag_z),
        .n    (flag_n),
        .v    (flag_v),
        .take (take)
    );

    always_comb begin
        wr_all  = 1'b0;
        wr_z    = 1'b0;
        we_eff  = ex_we;
        xfer    = 1'b0;
        xfer_pc = ex_br_target;
        res_eff = ex_alu_dst;
        rd_eff  = ex_rd;
        unique case (op)
            OP_ADD, OP_SUB: wr_all = 1'b1;
            // ADDZ only commits when Z is already set
            OP_ADDZ: begin
                wr_all = flag_z;
                we_eff = ex_we & flag_z;
            end
            OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA: wr_z = 1'b1;
            OP_B: begin
                we_eff = 1'b0;
                xfer   = take;
            end
            OP_JAL: begin
                we_eff  = 1'b1;
                xfer    = 1'b1;
                res_eff = ex_pc1;
                rd_eff  = RW'(15);
            end
            OP_JR: begin
                xfer    = 1'b1;
                xfer_pc = ex_jr_target;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid   <= 1'b0;
            mem_result  <= '0;
            mem_st_data <= '0;
            mem_rd      <= '0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_wr      <= 1'b0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            flag_v      <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            halted      <= 1'b0;
        end else if (!mem_stall) begin
            mem_valid <= acc;
            mem_we    <= acc & we_eff;
            mem_re    <= acc & (op == OP_LW);
            mem_wr    <= acc & (op == OP_SW);
            redirect  <= acc & xfer;
            if (acc) begin
                mem_result  <= res_eff;
                mem_st_data <= ex_st_data;
                mem_rd      <= rd_eff;
            end
            if (acc && xfer) begin
                redirect_pc <= xfer_pc;
            end
            if (acc && wr_all) begin
                flag_z <= ex_z;
                flag_n <= ex_n;
                flag_v <= ex_ov;
            end else if (acc && wr_z) begin
                flag_z <= ex_z;
            end
            if (acc && op == OP_HLT) begin
                halted <= 1'b1;
            end
        end
    end

endmodule
